// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin index arbiter.
// Contents: index/request widths, FSM state type, hold-counter width helper.
package rr_arb_pkg;

    localparam int unsigned IDX_W         = 5;
    localparam int unsigned N_REQ         = 2 ** IDX_W;
    localparam int unsigned MAX_HOLD_DFLT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } arb_state_e;

    // Hold counter only needs to reach max_hold-1.
    function automatic int unsigned hold_w(input int unsigned max_hold);
        return $clog2(max_hold);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first over the request vector.
// Ports:
//   req    - request vector, bit i requests index i
//   ptr    - index with highest priority this round
//   winner - first set bit of req at or above ptr, wrapping to 0
//   any    - at least one request present
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [2*N_REQ-1:0] w_dbl_shift;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_enc;

    // Doubling the vector turns the rotate-right into a plain shift.
    assign w_dbl_shift = {req, req} >> ptr;
    assign w_rot       = w_dbl_shift[N_REQ-1:0];

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        w_enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = IDX_W'(i);
            end
        end
    end

    // Adding ptr back undoes the rotation; IDX_W-bit add wraps mod N_REQ.
    assign winner = w_enc + ptr;
    assign any    = |req;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over N_REQ request lines, emitting the winner as an
// index plus enable for a downstream 5-to-32 decoder. A grant is held until
// released, withdrawn or MAX_HOLD cycles elapse, followed by one idle GAP cycle.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   req        - request vector
//   release_i  - grantee done; only looked at while a grant is held
//   grant_en   - grant valid (decoder enable)
//   grant_idx  - granted index (decoder input); stale while grant_en=0
//   timeout    - one-cycle pulse in the GAP cycle after a forced revoke
//   busy       - high while holding a grant
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic             grant_en,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout,
    output logic             busy
);

    localparam int unsigned     HoldW    = hold_w(MAX_HOLD);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    arb_state_e       r_state, w_state_next;
    logic [IDX_W-1:0] r_ptr, w_ptr_next;
    logic [HoldW-1:0] r_hold_cnt, w_hold_cnt_next;
    logic [IDX_W-1:0] r_grant_idx, w_grant_idx_next;
    logic             r_grant_en, w_grant_en_next;
    logic             r_timeout, w_timeout_next;
    logic             r_busy, w_busy_next;

    logic [IDX_W-1:0] w_winner;
    logic             w_any;
    logic             w_withdraw;
    logic             w_expired;
    logic             w_exit;

    rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_withdraw = ~req[r_grant_idx];
    assign w_expired  = (r_hold_cnt == HoldLast);
    assign w_exit     = release_i | w_withdraw | w_expired;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any) w_state_next = StGrant;
            StGrant: if (w_exit) w_state_next = StGap;
            StGap:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_ptr_next       = r_ptr;
        w_hold_cnt_next  = r_hold_cnt;
        w_grant_idx_next = r_grant_idx;
        w_grant_en_next  = 1'b0;
        w_timeout_next   = 1'b0;
        w_busy_next      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_grant_idx_next = w_winner;
                    w_grant_en_next  = 1'b1;
                    w_busy_next      = 1'b1;
                    w_hold_cnt_next  = '0;
                end
            end
            StGrant: begin
                if (w_exit) begin
                    // Release and withdrawal take precedence over the timeout.
                    w_timeout_next = ~release_i & ~w_withdraw;
                    w_ptr_next     = r_grant_idx + IDX_W'(1);
                end else begin
                    w_grant_en_next = 1'b1;
                    w_busy_next     = 1'b1;
                    if (!w_expired) begin
                        w_hold_cnt_next = r_hold_cnt + HoldW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_grant_idx <= '0;
            r_grant_en  <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_grant_idx <= w_grant_idx_next;
            r_grant_en  <= w_grant_en_next;
            r_timeout   <= w_timeout_next;
            r_busy      <= w_busy_next;
        end
    end

    assign grant_en  = r_grant_en;
    assign grant_idx = r_grant_idx;
    assign timeout   = r_timeout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rr_index_arbiter.sv
module tb_rr_index_arbiter;

    localparam int MAX_HOLD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        release_i;
    logic        grant_en;
    logic [4:0]  grant_idx;
    logic        timeout;
    logic        busy;

    rr_index_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .release_i (release_i),
        .grant_en  (grant_en),
        .grant_idx (grant_idx),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [4:0] idx;
        logic       to;
        logic       busy;
        logic       gap;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: 0 idle, 1 grant, 2 gap
    int         m_state;
    logic [4:0] m_ptr;
    logic [4:0] m_idx;
    int         m_hold;
    logic       m_en;
    logic       m_to;
    logic       m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = '0;
        m_idx   = '0;
        m_hold  = 0;
        m_en    = 1'b0;
        m_to    = 1'b0;
        m_busy  = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_edge(input logic [31:0] rq, input logic rel);
        logic found;
        int   j;
        m_to = 1'b0;
        case (m_state)
            0: begin
                if (rq != 32'd0) begin
                    found = 1'b0;
                    for (int k = 0; k < 32; k++) begin
                        j = (int'(m_ptr) + k) % 32;
                        if (!found && rq[j]) begin
                            found = 1'b1;
                            m_idx = 5'(j);
                        end
                    end
                    m_en    = 1'b1;
                    m_busy  = 1'b1;
                    m_hold  = 0;
                    m_state = 1;
                end
            end
            1: begin
                if (rel || !rq[m_idx] || m_hold == MAX_HOLD - 1) begin
                    m_to    = !rel && rq[m_idx];
                    m_en    = 1'b0;
                    m_busy  = 1'b0;
                    m_ptr   = m_idx + 5'd1;
                    m_state = 2;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs and
    // check them once the edge has passed. The decoder is modelled here too.
    task automatic drive(input logic [31:0] rq, input logic rel);
        exp_t        e;
        logic [31:0] dec;
        req       = rq;
        release_i = rel;
        model_edge(rq, rel);
        e = '{en: m_en, idx: m_idx, to: m_to, busy: m_busy, gap: (m_state == 2)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("grant_en", 32'(grant_en), 32'(e.en));
            chk("grant_idx", 32'(grant_idx), 32'(e.idx));
            chk("timeout", 32'(timeout), 32'(e.to));
            chk("busy", 32'(busy), 32'(e.busy));
            dec = grant_en ? (32'd1 << grant_idx) : 32'd0;
            chk("dec_onehot0", 32'($onehot0(dec)), 32'd1);
            if (e.gap) chk("dec_gap_zero", dec, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt;
        int          waited;
        logic [31:0] rr;

        // Reset state
        rst       = 1'b1;
        req       = '0;
        release_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_en", 32'(grant_en), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        model_reset();

        drive(32'd0, 1'b0);
        drive(32'd0, 1'b1);          // release in IDLE is ignored

        // Single requester, one-cycle latency, release, re-grant
        drive(32'h0000_0100, 1'b0);
        chk("single_idx", 32'(grant_idx), 32'd8);
        chk("single_en", 32'(grant_en), 32'd1);
        drive(32'h0000_0100, 1'b0);
        drive(32'h0000_0100, 1'b1);
        chk("single_gap_en", 32'(grant_en), 32'd0);
        drive(32'h0000_0100, 1'b0);
        drive(32'h0000_0100, 1'b0);
        chk("regrant_idx", 32'(grant_idx), 32'd8);
        chk("regrant_en", 32'(grant_en), 32'd1);

        // Asynchronous reset in the middle of a grant
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_en", 32'(grant_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_idx", 32'(grant_idx), 32'd0);
        chk("async_rst_to", 32'(timeout), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(32'd0, 1'b0);

        // Rotation between 0 and 31
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (!grant_en && waited < 4) begin
                drive(32'h8000_0001, 1'b0);
                waited++;
            end
            chk("rot_granted", 32'(grant_en), 32'd1);
            chk("rot_idx", 32'(grant_idx), (g % 2 == 0) ? 32'd0 : 32'd31);
            drive(32'h8000_0001, 1'b1);
        end

        // Wrap: ptr lands on 31 after granting 30
        drive(32'h4000_0000, 1'b0);
        drive(32'h4000_0000, 1'b0);
        chk("wrap_pre_idx", 32'(grant_idx), 32'd30);
        drive(32'h4000_0004, 1'b1);
        drive(32'h4000_0004, 1'b0);
        drive(32'h4000_0004, 1'b0);
        chk("wrap_idx", 32'(grant_idx), 32'd2);
        drive(32'h0000_0020, 1'b1);

        // Timeout on index 5
        drive(32'h0000_0020, 1'b0);
        drive(32'h0000_0020, 1'b0);
        chk("to_idx", 32'(grant_idx), 32'd5);
        cnt = grant_en ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            drive(32'h0000_0020, 1'b0);
            if (!grant_en) break;
            cnt++;
        end
        chk("to_hold_cycles", 32'(cnt), 32'd16);
        chk("to_pulse", 32'(timeout), 32'd1);
        drive(32'h0000_00B0, 1'b0);
        chk("to_pulse_width", 32'(timeout), 32'd0);
        drive(32'h0000_00B0, 1'b0);
        chk("to_next_idx", 32'(grant_idx), 32'd7);

        // Release coincident with the last hold cycle: no timeout pulse
        repeat (15) drive(32'h0000_00B0, 1'b0);
        drive(32'h0000_00B0, 1'b1);
        chk("rel_vs_to_en", 32'(grant_en), 32'd0);
        chk("rel_vs_to_pulse", 32'(timeout), 32'd0);

        // Withdrawal ends the grant without a timeout
        drive(32'h0000_00B0, 1'b0);
        drive(32'h0000_00B0, 1'b0);
        chk("wd_idx", 32'(grant_idx), 32'd4);
        drive(32'h0000_00A0, 1'b0);
        chk("wd_en", 32'(grant_en), 32'd0);
        chk("wd_to", 32'(timeout), 32'd0);

        // Random traffic with decoder checks
        rr = $urandom;
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 3) == 0) rr = $urandom & $urandom & $urandom;
            drive(rr, ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
